// File: rtl/key_conditioner_pkg.sv
// Shared types and constants for the i4001 board input conditioning stage.
package key_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } deb_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_COUNT   = 250000;

    // Bits needed to hold 0..deb_count inclusive.
    function automatic int cnt_width(input int deb_count);
        return $clog2(deb_count + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_debounce_channel.sv
// One scalar input: synchroniser, four-state debounce FSM, and registered
// level plus rise/fall strobes.
module debounce_channel
    import key_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_COUNT   = DEF_DEB_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW      = cnt_width(DEB_COUNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_COUNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    deb_state_t             state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   level_nx, rise_nx, fall_nx;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            state  <= STABLE_LO;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            state  <= state_nx;
            cnt    <= cnt_nx;
            level  <= level_nx;
            rise   <= rise_nx;
            fall   <= fall_nx;
        end
    end

    // Acceptance is decided on the count alone, so a pulse of exactly
    // DEB_COUNT synced samples is accepted.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (synced) begin
                    state_nx = WAIT_HI;
                    cnt_nx   = CW'(1);
                end
            end
            WAIT_HI: begin
                if (cnt == CNT_MAX) begin
                    state_nx = STABLE_HI;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    rise_nx  = 1'b1;
                end else if (synced) begin
                    cnt_nx = cnt + 1'b1;
                end else begin
                    state_nx = STABLE_LO;
                    cnt_nx   = '0;
                end
            end
            STABLE_HI: begin
                if (!synced) begin
                    state_nx = WAIT_LO;
                    cnt_nx   = CW'(1);
                end
            end
            WAIT_LO: begin
                if (cnt == CNT_MAX) begin
                    state_nx = STABLE_LO;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                    fall_nx  = 1'b1;
                end else if (!synced) begin
                    cnt_nx = cnt + 1'b1;
                end else begin
                    state_nx = STABLE_HI;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = STABLE_LO;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_conditioner.sv
// Synchronises and debounces the board buttons, mode switch and DIP bank
// into clean levels and single-cycle strobes for the controller.
module key_conditioner
    import key_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_COUNT   = DEF_DEB_COUNT,
    parameter int N_SW        = 16
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            MCLK_RAW,
    input  logic            RESET_RAW,
    input  logic            SWITCH_RAW,
    input  logic [N_SW-1:0] in_raw,
    output logic            MCLK_LVL,
    output logic            MCLK_RISE,
    output logic            MCLK_FALL,
    output logic            RESET_LVL,
    output logic            RESET_RISE,
    output logic            SWITCH_LVL,
    output logic [N_SW-1:0] in,
    output logic            in_changed
);

    localparam int            CW       = cnt_width(DEB_COUNT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_COUNT - 1);

    logic reset_fall, switch_rise, switch_fall;
    logic unused_strobes;

    assign unused_strobes = ^{reset_fall, switch_rise, switch_fall};

    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEB_COUNT(DEB_COUNT)) u_mclk (
        .clk   (CLK),
        .rst_n (RESET_N),
        .raw   (MCLK_RAW),
        .level (MCLK_LVL),
        .rise  (MCLK_RISE),
        .fall  (MCLK_FALL)
    );

    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEB_COUNT(DEB_COUNT)) u_reset (
        .clk   (CLK),
        .rst_n (RESET_N),
        .raw   (RESET_RAW),
        .level (RESET_LVL),
        .rise  (RESET_RISE),
        .fall  (reset_fall)
    );

    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEB_COUNT(DEB_COUNT)) u_switch (
        .clk   (CLK),
        .rst_n (RESET_N),
        .raw   (SWITCH_RAW),
        .level (SWITCH_LVL),
        .rise  (switch_rise),
        .fall  (switch_fall)
    );

    logic [SYNC_STAGES-1:0][N_SW-1:0] vsync_q;
    logic [N_SW-1:0]                  vsynced, shadow;
    logic [CW-1:0]                    vcnt;

    assign vsynced = vsync_q[SYNC_STAGES-1];

    // Whole-vector debounce: any bit change restarts the stability count, so
    // staggered bit changes collapse into one update once the last settles.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vsync_q    <= '0;
            shadow     <= '0;
            vcnt       <= '0;
            in         <= '0;
            in_changed <= 1'b0;
        end else begin
            vsync_q    <= {vsync_q[SYNC_STAGES-2:0], in_raw};
            shadow     <= vsynced;
            in_changed <= 1'b0;
            if (vsynced != shadow) begin
                vcnt <= '0;
            end else if (vcnt != CNT_MAX) begin
                vcnt <= vcnt + 1'b1;
            end
            if (vcnt == CNT_LAST && shadow != in) begin
                in         <= shadow;
                in_changed <= 1'b1;
            end
        end
    end

endmodule
